// File: rtl/clic_nested.sv
// clic_nested -- nested core-local interrupt controller.
//
// Owns per-vector handler-address and entry CSRs, latches the external
// interrupt lines in level or edge mode, arbitrates enabled/pended vectors
// against the current threshold and redirects the fetch PC to the winning
// handler. Each take pushes {pc, thresh} onto a stack of depth PrioLevels;
// a return (pc_in all-ones) pops it. Over/underflow sets a sticky error.
//
// Optional feature macro: CLIC_TAIL_CHAIN_EN -- when defined, a return that
// finds a candidate above the stacked priority jumps straight to the new
// handler without popping.
//
// Ports:
//   clk, reset       clock, synchronous active-low reset
//   csr_enable       CSR instruction valid
//   csr_addr         CSR address
//   rs1_zimm         immediate operand (imm op variants)
//   rs1_data         register operand
//   csr_op           CSR operation
//   irq_in           external interrupt lines
//   pc_in            next PC; all-ones means return from interrupt
//   out              CSR read data (0 when unmapped)
//   pc_out           redirected next PC
//   int_taken        high in any cycle that redirects to a handler
//   stack_err        sticky stack overflow/underflow flag

package clic_nested_pkg;
   typedef enum logic [2:0] {
      CSR_NONE = 3'd0,
      CSR_RW   = 3'd1,
      CSR_RS   = 3'd2,
      CSR_RC   = 3'd3,
      CSR_RWI  = 3'd5,
      CSR_RSI  = 3'd6,
      CSR_RCI  = 3'd7
   } csr_op_t;
endpackage

// One interrupt vector: handler address, entry fields and pended latch.
module clic_entry #(
   parameter int PW = 3,
   parameter int VW = 30
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          irq,
   input  logic          wr_vec,
   input  logic          wr_entry,
   input  logic [VW-1:0] vec_wdata,
   input  logic [PW+2:0] ent_wdata,
   input  logic          take,
   output logic          pended,
   output logic          enabled,
   output logic [PW-1:0] prio,
   output logic          edge_mode,
   output logic [VW-1:0] vec
);
   logic irq_q;
   logic pend_nxt;
   logic sw_clr, sw_set;

   assign sw_clr = wr_entry & ~ent_wdata[0];
   assign sw_set = wr_entry & ent_wdata[0] & ~pended;

   // A rising edge always wins over a take or software clear in the same cycle.
   always_comb begin
      pend_nxt = irq;
      if (edge_mode)
         pend_nxt = (irq & ~irq_q) | sw_set | (pended & ~take & ~sw_clr);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         irq_q     <= 1'b0;
         pended    <= 1'b0;
         enabled   <= 1'b0;
         prio      <= '0;
         edge_mode <= 1'b0;
         vec       <= '0;
      end else begin
         irq_q  <= irq;
         pended <= pend_nxt;
         if (wr_vec)
            vec <= vec_wdata;
         if (wr_entry) begin
            enabled   <= ent_wdata[1];
            prio      <= ent_wdata[2 +: PW];
            edge_mode <= ent_wdata[PW+2];
         end
      end
   end
endmodule

module clic_nested
   import clic_nested_pkg::*;
#(
   parameter int          VecSize        = 8,
   parameter int          PrioLevels     = 8,
   parameter int          IMemAddrWidth  = 32,
   parameter logic [11:0] VecCsrBase     = 12'hb00,
   parameter logic [11:0] EntryCsrBase   = 12'hb20,
   parameter logic [11:0] MIntThreshAddr = 12'h347,
   parameter logic [11:0] StackDepthAddr = 12'h350
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     csr_enable,
   input  logic [11:0]              csr_addr,
   input  logic [4:0]               rs1_zimm,
   input  logic [31:0]              rs1_data,
   input  csr_op_t                  csr_op,
   input  logic [VecSize-1:0]       irq_in,
   input  logic [IMemAddrWidth-1:0] pc_in,
   output logic [31:0]              out,
   output logic [IMemAddrWidth-1:0] pc_out,
   output logic                     int_taken,
   output logic                     stack_err
);
   localparam int PW = $clog2(PrioLevels);
   localparam int DW = $clog2(PrioLevels + 1);
   localparam int EW = PW + 3;
   localparam int VW = IMemAddrWidth - 2;
   localparam int IW = (VecSize > 1) ? $clog2(VecSize) : 1;

   logic [VecSize-1:0]          pended, enabled, edge_mode;
   logic [VecSize-1:0][PW-1:0]  prio;
   logic [VecSize-1:0][VW-1:0]  vec;
   logic [VecSize-1:0]          wr_vec, wr_entry, take_vec;

   logic [PW-1:0]               thresh;
   logic [DW-1:0]               depth;
   logic [PrioLevels-1:0][IMemAddrWidth-1:0] stk_pc;
   logic [PrioLevels-1:0][PW-1:0]            stk_pr;
   logic [PW-1:0]               top_idx;

   logic [31:0] src, wdata;
   logic        csr_we, wr_thresh;
   logic        unused_wdata;

   logic          nt_hit;
   logic [IW-1:0] nt_idx;
   logic [PW-1:0] nt_pr;

   logic          do_push, do_pop, set_err, hw_thresh_we;
   logic [PW-1:0] hw_thresh;
   logic          is_ret, full, empty;

   // ---------------- CSR read / write data ----------------
   always_comb begin
      out = '0;
      if (csr_addr == MIntThreshAddr) out = 32'(thresh);
      if (csr_addr == StackDepthAddr) out = 32'(depth);
      for (int k = 0; k < VecSize; k++) begin
         if (csr_addr == VecCsrBase + 12'(k))
            out = 32'(vec[k]);
         if (csr_addr == EntryCsrBase + 12'(k))
            out = 32'({edge_mode[k], prio[k], enabled[k], pended[k]});
      end
   end

   always_comb begin
      src    = csr_op[2] ? 32'(rs1_zimm) : rs1_data;
      wdata  = src;
      csr_we = csr_enable;
      case (csr_op)
         CSR_RW, CSR_RWI: wdata = src;
         CSR_RS, CSR_RSI: wdata = out | src;
         CSR_RC, CSR_RCI: wdata = out & ~src;
         default:         csr_we = 1'b0;
      endcase
   end

   assign unused_wdata = ^wdata;
   assign wr_thresh    = csr_we && (csr_addr == MIntThreshAddr);

   always_comb begin
      for (int k = 0; k < VecSize; k++) begin
         wr_vec[k]   = csr_we && (csr_addr == VecCsrBase + 12'(k));
         wr_entry[k] = csr_we && (csr_addr == EntryCsrBase + 12'(k));
      end
   end

   // ---------------- per-vector state ----------------
   for (genvar k = 0; k < VecSize; k++) begin : g_vec
      clic_entry #(.PW(PW), .VW(VW)) u_entry (
         .clk       (clk),
         .reset     (reset),
         .irq       (irq_in[k]),
         .wr_vec    (wr_vec[k]),
         .wr_entry  (wr_entry[k]),
         .vec_wdata (wdata[VW-1:0]),
         .ent_wdata (wdata[EW-1:0]),
         .take      (take_vec[k]),
         .pended    (pended[k]),
         .enabled   (enabled[k]),
         .prio      (prio[k]),
         .edge_mode (edge_mode[k]),
         .vec       (vec[k])
      );
   end

   // ---------------- arbitration ----------------
   // Ascending scan with >= lets the highest index win a priority tie.
   always_comb begin
      nt_hit = 1'b0;
      nt_idx = '0;
      nt_pr  = '0;
      for (int k = 0; k < VecSize; k++)
         if (enabled[k] && pended[k] && prio[k] > thresh && prio[k] >= nt_pr) begin
            nt_hit = 1'b1;
            nt_idx = IW'(k);
            nt_pr  = prio[k];
         end
   end

   assign is_ret  = &pc_in;
   assign full    = (depth == DW'(PrioLevels));
   assign empty   = (depth == '0);
   assign top_idx = PW'(depth - DW'(1));

`ifdef CLIC_TAIL_CHAIN_EN
   // Second arbiter referenced to the stacked priority, used on return.
   logic          tc_hit;
   logic [IW-1:0] tc_idx;
   logic [PW-1:0] tc_pr;

   always_comb begin
      tc_hit = 1'b0;
      tc_idx = '0;
      tc_pr  = '0;
      for (int k = 0; k < VecSize; k++)
         if (enabled[k] && pended[k] && prio[k] > stk_pr[top_idx] && prio[k] >= tc_pr) begin
            tc_hit = 1'b1;
            tc_idx = IW'(k);
            tc_pr  = prio[k];
         end
   end
`endif

   // ---------------- redirect control ----------------
   always_comb begin
      pc_out       = pc_in;
      int_taken    = 1'b0;
      do_push      = 1'b0;
      do_pop       = 1'b0;
      set_err      = 1'b0;
      hw_thresh_we = 1'b0;
      hw_thresh    = '0;
      take_vec     = '0;
      if (reset) begin
         if (is_ret) begin
            if (empty)
               set_err = 1'b1;
`ifdef CLIC_TAIL_CHAIN_EN
            else if (tc_hit) begin
               pc_out           = {vec[tc_idx], 2'b00};
               int_taken        = 1'b1;
               take_vec[tc_idx] = 1'b1;
               hw_thresh_we     = 1'b1;
               hw_thresh        = tc_pr;
            end
`endif
            else begin
               do_pop       = 1'b1;
               pc_out       = stk_pc[top_idx];
               hw_thresh_we = 1'b1;
               hw_thresh    = stk_pr[top_idx];
            end
         end else if (nt_hit) begin
            if (full)
               set_err = 1'b1;
            else begin
               do_push          = 1'b1;
               pc_out           = {vec[nt_idx], 2'b00};
               int_taken        = 1'b1;
               take_vec[nt_idx] = 1'b1;
               hw_thresh_we     = 1'b1;
               hw_thresh        = nt_pr;
            end
         end
      end
   end

   // ---------------- state ----------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         thresh    <= '0;
         depth     <= '0;
         stack_err <= 1'b0;
      end else begin
         if (hw_thresh_we)
            thresh <= hw_thresh;
         else if (wr_thresh)
            thresh <= wdata[PW-1:0];
         depth     <= depth + DW'(do_push) - DW'(do_pop);
         stack_err <= stack_err | set_err;
      end
   end

   // Stack contents need no reset: depth alone defines what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         stk_pc[PW'(depth)] <= pc_in;
         stk_pr[PW'(depth)] <= thresh;
      end
   end
endmodule

// File: doc/clic_nested.md
# clic_nested

Parametrised nested core-local interrupt controller; successor to the current single-mode CLIC. It owns per-vector handler-address and entry CSRs, latches hardware interrupt lines in per-vector level or edge mode, and arbitrates enabled, pended vectors against the interrupt threshold. It manages a threshold/return-address stack with overflow/underflow detection, and optionally tail-chains on return. It sits beside the CSR file in the fetch stage and redirects `pc_out`.

## Interface
- `VecSize`, default 8: number of vectors and external interrupt lines (max 32).
- `PrioLevels`, default 8: priority levels; `PrioWidth = $clog2(PrioLevels)`. Stack depth equals `PrioLevels`.
- `VecCsrBase`, default 'hb00: CSR address of vector 0 handler address.
- `EntryCsrBase`, default 'hb20: CSR address of vector 0 entry.
- `MIntThreshAddr`, default 'h347: threshold CSR, read/write.
- `StackDepthAddr`, default 'h350: stack depth CSR, read-only.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset.
- `csr_enable`  in  1  CSR instruction valid.
- `csr_addr`  in  12  CSR address.
- `rs1_zimm`  in  5  immediate operand.
- `rs1_data`  in  32  register operand.
- `csr_op`  in  csr_op_t  CSR operation (RW/RS/RC, imm variants).
- `irq_in`  in  VecSize  external interrupt lines, synchronous to `clk`.
- `pc_in`  in  IMemAddrWidth  next PC; all-ones means return from interrupt.
- `out`  out  32  CSR read data; 0 for unmapped addresses.
- `pc_out`  out  IMemAddrWidth  redirected next PC.
- `int_taken`  out  1  high in any cycle that redirects to a handler.
- `stack_err`  out  1  sticky stack overflow or underflow flag.

## Operation
- Entry layout, LSB first: `pended`, `enabled`, `prio[PrioWidth]`, `edge`. `edge`=0 selects level mode; `edge`=1 selects edge mode.
- Vector CSR holds the word address (IMemAddrWidth-2 bits). The redirect target is `{vec, 2'b00}`.
- Level mode: `pended` is loaded from `irq_in[k]` every cycle, and software writes to `pended` are ignored.
- Edge mode: a rising edge (`irq_in & ~irq_q`) sets `pended`. `pended` clears when the vector is taken or when software clears it. If a rising edge coincides with the take or the software clear, `pended` stays 1.
- Arbitration candidates are vectors that are enabled, pended, and have `prio` above the reference level. On a priority tie, the highest index wins.
- Normal take: candidate exists and `pc_in` is not all-ones.
  - Push `{pc_in, thresh}`.
  - Set `thresh` to the winning prio.
  - `pc_out` = winning handler, `int_taken`=1.
- Return (`pc_in` all-ones) with no tail-chain: pop. `pc_out` = stacked address, `thresh` = stacked prio.
- Tail chain (macro on): `pc_in` all-ones and a candidate exists above the stacked prio.
  - No push and no pop.
  - `thresh` = winner prio, `pc_out` = winner handler, `int_taken`=1.
- Stack full on take: the interrupt is not taken, `pc_out` = `pc_in`, and `stack_err` is set.
- Stack empty on return: `pc_out` = `pc_in`, and `stack_err` is set.
- CSR writes to `thresh` are masked to PrioWidth. A hardware threshold update in the same cycle wins over the CSR write.
- The stack depth CSR reads the 0..PrioLevels count, zero-extended.

## Timing
- Reset values: all vector and entry CSRs 0, `thresh` 0, `irq_q` 0, stack empty, depth 0, `stack_err` 0.
- During reset, `int_taken`=0 and `pc_out` = `pc_in`.
- Arbitration, `pc_out`, `int_taken` and `out` are combinational from registered state plus `pc_in`, `csr_addr` and the CSR operands.
- All state updates (push, pop, `thresh`, `pended`) occur at the next rising edge.
- Interrupt latency:
  - Edge mode: `irq_in` rises in cycle N, `pended` is set at edge N+1, and the redirect happens in cycle N+1.
  - Level mode: same latency, N+1.
- A CSR write in cycle N is visible to arbitration and readback from cycle N+1.
- Reset asserted mid-handler empties the stack and discards the return context.

## Configuration
- `CLIC_TAIL_CHAIN_EN` defined: tail chaining on return as described above.
- Not defined: a return always pops. A pending higher-prio vector is then taken in the following cycle through the normal path, with a push.

## Test plan
- Priority and threshold: vec 2 (prio 3) and vec 5 (prio 6) both enabled and pended, `thresh`=0.
  - Required: `pc_out`={vec5,00}, `int_taken`=1, `thresh`=6 next cycle, depth CSR reads 1.
- Nesting and return: take prio 2 at pc 0x40, then prio 5 at pc 0x80, then two returns.
  - Required: `pc_out`=0x80 with `thresh`=2, then `pc_out`=0x40 with `thresh`=0, then depth 0.
- Edge versus take collision: an edge on vec 1 arrives in the same cycle vec 1 is taken.
  - Required: `pended` stays 1, and vec 1 is re-taken after return.
- Level mode: `irq_in[3]` held high 1 cycle, then low, with no take.
  - Required: `pended` is 1 for exactly one cycle.
  - Required: a software write of `pended`=1 has no effect.
- Tail chain, with and without the macro: return from a prio 4 handler, stacked prio 0, vec 6 (prio 2) pended.
  - Macro on: `pc_out`={vec6,00} in the return cycle, with no pop.
  - Macro off: pop to the saved pc, then vec 6 is taken the next cycle.
- Stack errors:
  - A return with the stack empty sets `stack_err` and gives `pc_out`=all-ones.
  - Forcing `thresh` to 0 via CSR after each take until PrioLevels pushes fill the stack: the next take is blocked and `stack_err` stays 1 until reset.
